// File: rtl/spi_pkg.sv
// Shared definitions for the SPI read/write slave: the frame state encoding
// and a small helper used to size the bit counter.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised copy (one CLK cycle wide).
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_rw.sv
// SPI mode-0 slave bridging R/W + address + data frames onto a simple
// register-bus strobe interface, with optional address auto-increment bursts.
module spi_slave_rw
    import spi_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int BURST = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CS,
    input  logic          SCLK,
    input  logic          SDATA,
    output logic          SDO,
    output logic          SDO_OE,
    output logic          WEN,
    output logic          REN,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] WDATA,
    input  logic [DW-1:0] RDATA
);

    localparam int            CW        = $clog2(max2(AW, DW) + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic          BURST_EN  = (BURST != 0);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic sdata_s, sdata_rise, sdata_fall;
    logic unused_sync;

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_i(CLK), .rst_ni(RSTN), .async_i(CS),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(CLK), .rst_ni(RSTN), .async_i(SCLK),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_sdata (
        .clk_i(CLK), .rst_ni(RSTN), .async_i(SDATA),
        .sync_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
    );

    assign unused_sync = ^{cs_rise, sclk_s, sdata_rise, sdata_fall};

    spi_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wsh_q;
    logic [DW-1:0] tx_q;
    logic [DW-1:0] wdata_q;
    logic          wen_q, ren_q, rd_load_q;
    logic          sdo_q, oe_q;
    logic [1:0]    fill_q;
    logic          armed_q;

    logic [AW-1:0] addr_shift_d;
    logic [DW-1:0] word_d;

    always_comb begin
        addr_shift_d = AW'({addr_q, sdata_s});
        word_d       = DW'({wsh_q, sdata_s});
    end

    // armed_q only sets once the CS synchroniser holds a real high sample, so a
    // CS already low when reset releases cannot be mistaken for a frame start.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wsh_q     <= '0;
            tx_q      <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            rd_load_q <= 1'b0;
            sdo_q     <= 1'b0;
            oe_q      <= 1'b0;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            rd_load_q <= ren_q;
            oe_q      <= ~cs_s;
            sdo_q     <= (state_q == ST_DATA && rw_q) ? tx_q[DW-1] : 1'b0;
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && cs_s) armed_q <= 1'b1;
            if (rd_load_q) tx_q <= RDATA;
            if (wen_q && BURST_EN) addr_q <= addr_q + AW'(1);

            if (cs_s) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall && armed_q) begin
                            state_q <= ST_CMD;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rw_q    <= sdata_s;
                            state_q <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr_q <= addr_shift_d;
                            if (cnt_q == ADDR_LAST) begin
                                cnt_q   <= '0;
                                state_q <= ST_DATA;
                                ren_q   <= rw_q;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            wsh_q <= word_d;
                            if (cnt_q == DATA_LAST) begin
                                cnt_q <= '0;
                                if (rw_q) begin
                                    ren_q <= BURST_EN;
                                    if (BURST_EN) addr_q <= addr_q + AW'(1);
                                end else begin
                                    wen_q   <= 1'b1;
                                    wdata_q <= word_d;
                                end
                                if (!BURST_EN) state_q <= ST_DONE;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        // the fall right after a word boundary keeps the freshly loaded MSB
                        end else if (sclk_fall && rw_q && cnt_q != '0) begin
                            tx_q <= tx_q << 1;
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign SDO    = sdo_q;
    assign SDO_OE = oe_q;
    assign WEN    = wen_q;
    assign REN    = ren_q;
    assign ADDR   = addr_q;
    assign WDATA  = wdata_q;

endmodule

// File: tb/tb_spi_slave_rw.sv
// Directed bench: a BURST=0 and a BURST=1 slave share the SPI pins, each with
// its own chip select; strobes are logged and compared against vector tables.
module tb_spi_slave_rw;

    localparam int H = 10;  // CLK cycles per SCLK half period (20x ratio)

    logic       CLK = 1'b0;
    logic       RSTN, CS0, CS1, SCLK, SDATA;
    logic       SDO0, OE0, WEN0, REN0;
    logic       SDO1, OE1, WEN1, REN1;
    logic [7:0] ADDR0, WDATA0, ADDR1, WDATA1;
    logic [7:0] RDATA0 = 8'h00;
    logic [7:0] RDATA1 = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    spi_slave_rw #(.AW(8), .DW(8), .BURST(0)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .CS(CS0), .SCLK(SCLK), .SDATA(SDATA),
        .SDO(SDO0), .SDO_OE(OE0), .WEN(WEN0), .REN(REN0),
        .ADDR(ADDR0), .WDATA(WDATA0), .RDATA(RDATA0)
    );
    spi_slave_rw #(.AW(8), .DW(8), .BURST(1)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .CS(CS1), .SCLK(SCLK), .SDATA(SDATA),
        .SDO(SDO1), .SDO_OE(OE1), .WEN(WEN1), .REN(REN1),
        .ADDR(ADDR1), .WDATA(WDATA1), .RDATA(RDATA1)
    );

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    // read-back memory: answers one cycle after REN
    always @(posedge CLK) begin
        if (REN0) RDATA0 <= mem_f(ADDR0);
        if (REN1) RDATA1 <= mem_f(ADDR1);
    end

    // strobe log entry: {src, is_read, addr, wdata (0 for reads)}
    logic [17:0] stb_q[$];

    always @(negedge CLK) begin
        if (WEN0) stb_q.push_back({1'b0, 1'b0, ADDR0, WDATA0});
        if (REN0) stb_q.push_back({1'b0, 1'b1, ADDR0, 8'h00});
        if (WEN1) stb_q.push_back({1'b1, 1'b0, ADDR1, WDATA1});
        if (REN1) stb_q.push_back({1'b1, 1'b1, ADDR1, 8'h00});
        if ((WEN0 && REN0) || (WEN1 && REN1)) begin
            errors++;
            $display("FAIL wen_ren_overlap t=%0t act=%b%b%b%b required=no overlap",
                     $time, WEN0, REN0, WEN1, REN1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic set_cs(input bit sel, input logic v);
        if (sel) CS1 = v;
        else     CS0 = v;
    endtask

    task automatic send_bit(input bit sel, input logic b, output logic so);
        SDATA = b;
        repeat (H) @(negedge CLK);
        so   = sel ? SDO1 : SDO0;
        SCLK = 1'b1;
        repeat (H) @(negedge CLK);
        SCLK = 1'b0;
    endtask

    task automatic run_frame(input bit sel, input bit rw, input logic [7:0] addr,
                             input int nbits, input logic [23:0] dat,
                             output logic [8:0] hdr_sdo, output logic [23:0] d_sdo,
                             output logic oe_mid, output logic oe_end);
        logic s;
        hdr_sdo = '0;
        d_sdo   = '0;
        set_cs(sel, 1'b0);
        repeat (H) @(negedge CLK);
        oe_mid = sel ? OE1 : OE0;
        send_bit(sel, rw, s);
        hdr_sdo[8] = s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(sel, addr[i], s);
            hdr_sdo[i] = s;
        end
        for (int k = 0; k < nbits; k++) begin
            send_bit(sel, dat[23-k], s);
            d_sdo[23-k] = s;
        end
        repeat (H) @(negedge CLK);
        set_cs(sel, 1'b1);
        repeat (4*H) @(negedge CLK);
        oe_end = sel ? OE1 : OE0;
    endtask

    typedef struct {
        bit          sel;    // 0: BURST=0 slave, 1: BURST=1 slave
        bit          rw;
        logic [7:0]  addr;
        int          nbits;
        logic [23:0] dat;    // first data bit at [23]
        int          exp_n;
        logic [31:0] ea;     // expected strobe addresses, first in [31:24]
        logic [31:0] ed;     // expected write data, first in [31:24]
        logic [23:0] esdo;   // expected SDO over the data phase
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [8:0]  hdr;
        logic [23:0] dsdo;
        logic [23:0] mask;
        logic        oe_m, oe_e, s;
        logic [17:0] got, expv;
        int          n;

        vecs[0]  = '{1'b1, 1'b0, 8'h3C,  8, 24'hA50000, 1, 32'h3C000000, 32'hA5000000, 24'h000000};
        vecs[1]  = '{1'b0, 1'b0, 8'h3C, 16, 24'hA5FF00, 1, 32'h3C000000, 32'hA5000000, 24'h000000};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 24, 24'h010203, 3, 32'hFF000100, 32'h01020300, 24'h000000};
        vecs[3]  = '{1'b0, 1'b1, 8'h10,  8, 24'h000000, 1, 32'h10000000, 32'h00000000, 24'h5A0000};
        vecs[4]  = '{1'b1, 1'b1, 8'h10, 16, 24'h000000, 3, 32'h10111200, 32'h00000000, 24'h5A5B00};
        vecs[5]  = '{1'b1, 1'b0, 8'h7E, 12, 24'h123000, 1, 32'h7E000000, 32'h12000000, 24'h000000};
        vecs[6]  = '{1'b0, 1'b0, 8'h00,  8, 24'h000000, 1, 32'h00000000, 32'h00000000, 24'h000000};
        vecs[7]  = '{1'b1, 1'b0, 8'h80,  8, 24'hFF0000, 1, 32'h80000000, 32'hFF000000, 24'h000000};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF,  8, 24'h000000, 1, 32'hFF000000, 32'h00000000, 24'hB50000};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF,  8, 24'h000000, 2, 32'hFF000000, 32'h00000000, 24'hB50000};
        vecs[10] = '{1'b0, 1'b1, 8'h10, 16, 24'h000000, 1, 32'h10000000, 32'h00000000, 24'h5A0000};

        RSTN = 1'b0; CS0 = 1'b1; CS1 = 1'b1; SCLK = 1'b0; SDATA = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_dut0", {12'h0, WEN0, REN0, SDO0, OE0, ADDR0, WDATA0}, 32'h0);
        chk("reset_dut1", {12'h0, WEN1, REN1, SDO1, OE1, ADDR1, WDATA1}, 32'h0);
        RSTN = 1'b1;
        repeat (10) @(negedge CLK);
        chk("idle_no_strobe", stb_q.size(), 0);

        for (int v = 0; v < 11; v++) begin
            stb_q.delete();
            run_frame(vecs[v].sel, vecs[v].rw, vecs[v].addr, vecs[v].nbits, vecs[v].dat,
                      hdr, dsdo, oe_m, oe_e);
            chk($sformatf("v%0d_nstrobe", v), stb_q.size(), vecs[v].exp_n);
            n = (stb_q.size() < vecs[v].exp_n) ? stb_q.size() : vecs[v].exp_n;
            for (int i = 0; i < n; i++) begin
                got  = stb_q[i];
                expv = {vecs[v].sel, vecs[v].rw, vecs[v].ea[31-8*i -: 8],
                        vecs[v].rw ? 8'h00 : vecs[v].ed[31-8*i -: 8]};
                chk($sformatf("v%0d_strobe%0d", v, i), got, expv);
            end
            mask = 24'hFFFFFF;
            mask = mask << (24 - vecs[v].nbits);
            chk($sformatf("v%0d_sdo_hdr", v), hdr, 0);
            chk($sformatf("v%0d_sdo_data", v), dsdo & mask, vecs[v].esdo);
            chk($sformatf("v%0d_oe_mid", v), oe_m, 1);
            chk($sformatf("v%0d_oe_end", v), oe_e, 0);
        end

        // reset pulsed mid-address; the remainder of that frame must be ignored
        stb_q.delete();
        CS1 = 1'b0;
        repeat (H) @(negedge CLK);
        send_bit(1'b1, 1'b0, s);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, s);
        RSTN = 1'b0;
        #1;
        chk("midrst_async_clear", {12'h0, WEN1, REN1, SDO1, OE1, ADDR1, WDATA1}, 32'h0);
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1, s);
        repeat (H) @(negedge CLK);
        CS1 = 1'b1;
        repeat (4*H) @(negedge CLK);
        chk("midrst_no_strobe", stb_q.size(), 0);

        stb_q.delete();
        run_frame(1'b1, 1'b0, 8'h22, 8, 24'h110000, hdr, dsdo, oe_m, oe_e);
        chk("postrst_nstrobe", stb_q.size(), 1);
        if (stb_q.size() > 0) chk("postrst_strobe", stb_q[0], {1'b1, 1'b0, 8'h22, 8'h11});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rw.md
SPI_SLAVE_RW -- requirements
Module: spi_slave_rw

Interface
REQ-001 Parameter AW, default 8: address width in bits, 1..16.
REQ-002 Parameter DW, default 8: data word width in bits, 1..32.
REQ-003 Parameter BURST, default 1: 1 enables address auto-increment over consecutive data words; 0 allows a single word per frame.
REQ-004 CLK  input  1  system clock; all logic is clocked on its rising edge.
REQ-005 RSTN  input  1  reset; asynchronous assert, active-low.
REQ-006 CS  input  1  SPI chip select, active-high deselect; asynchronous to CLK.
REQ-007 SCLK  input  1  SPI clock, mode 0; asynchronous to CLK.
REQ-008 SDATA  input  1  SPI serial data in (MOSI); asynchronous to CLK.
REQ-009 SDO  output  1  SPI serial data out (MISO).
REQ-010 SDO_OE  output  1  SDO output enable; 1 while CS is low after synchronisation.
REQ-011 WEN  output  1  write strobe, one CLK cycle wide.
REQ-012 REN  output  1  read request strobe, one CLK cycle wide.
REQ-013 ADDR  output  AW  address for WEN/REN, valid while the strobe is high.
REQ-014 WDATA  output  DW  write data, valid while WEN is high.
REQ-015 RDATA  input  DW  read data, sampled exactly one CLK cycle after REN.

Function
REQ-016 CS, SCLK and SDATA shall each pass through a 2-flop synchroniser; SCLK rising and falling edges shall be detected from the synchronised copy.
REQ-017 CLK frequency shall be at least 16x the SCLK frequency; behaviour below that ratio is undefined.
REQ-018 Frame format, MSB first, sampled on SCLK rising edges: 1 R/W bit (1 = read), AW address bits, then DW-bit data words.
REQ-019 State machine: IDLE -> CMD on synchronised CS falling; CMD -> ADDR after 1 bit; ADDR -> DATA after AW bits; DATA -> DATA per word when BURST=1, or DATA -> DONE after one word when BURST=0; any state -> IDLE on synchronised CS high.
REQ-020 A bit counter of width clog2(max(AW,DW)+1) shall count the bits of the current field and reset to 0 at every field boundary.
REQ-021 Write: WEN shall pulse on the CLK cycle after the detected SCLK edge that completes a data word, with ADDR and WDATA holding that word.
REQ-022 Read: REN shall pulse on the CLK cycle after the edge that completes the address, and again at each word boundary when BURST=1; RDATA shall be loaded into the output shift register the following cycle.
REQ-023 SDO shall present the read data MSB before the first data-phase SCLK rising edge and shift on each detected SCLK falling edge; SDO shall be 0 in write frames and outside the data phase.
REQ-024 Burst: ADDR shall increment by 1 after each word and wrap from 2^AW-1 to 0.
REQ-025 In DONE (BURST=0), further SCLK edges shall be ignored until CS goes high.
REQ-026 CS high mid-word shall abort the word: no WEN for the partial word; words already completed remain committed.
REQ-027 WEN and REN shall never be high in the same cycle.

Reset
REQ-028 RSTN low shall immediately set the state to IDLE, the counter, shift registers and synchronisers to 0 (CS synchroniser to 1), and WEN, REN, SDO, SDO_OE, ADDR and WDATA to 0.
REQ-029 Reset asserted mid-frame shall produce no strobe; after release the block shall wait for a fresh CS falling edge.

Structure
REQ-030 The state encoding (IDLE, CMD, ADDR, DATA, DONE) shall reside in shared package spi_pkg.
REQ-031 The synchroniser plus edge detector shall be a sub-module named spi_sync, instantiated once per asynchronous input.

Verification
REQ-032 AW=8, DW=8: write frame R/W=0, addr 0x3C, data 0xA5 -> one WEN, ADDR=0x3C, WDATA=0xA5.
REQ-033 Read frame addr 0x10, RDATA=0x5A -> REN with ADDR=0x10; SDO shifts out 01011010.
REQ-034 BURST=1, write addr 0xFF with 3 words 0x01, 0x02, 0x03 -> WEN at ADDR 0xFF, 0x00, 0x01 in that order.
REQ-035 BURST=0, write frame followed by 8 extra SCLK cycles -> exactly one WEN.
REQ-036 CS raised after 4 data bits of the second burst word -> only the first WEN occurs.
REQ-037 RSTN pulsed low mid-address, then a clean write frame addr 0x22, data 0x11 -> no strobe during the aborted frame; one WEN with ADDR=0x22, WDATA=0x11.
